// File: rtl/max_pool_stream_if.sv
// Handshake bundle for max_pool_stream: input beat channel plus pooled result channel.
// out_index is only present when MAXPOOL_ARGMAX_EN is defined.
interface max_pool_stream_if #(
    parameter int BITWIDTH = 16,
    parameter int CHANNELS = 4,
    parameter int WINDOW   = 4
);
    localparam int IDXW = $clog2(WINDOW);

    logic                         in_valid;
    logic                         in_ready;
    logic [BITWIDTH*CHANNELS-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [BITWIDTH*CHANNELS-1:0] out_data;
`ifdef MAXPOOL_ARGMAX_EN
    logic [IDXW*CHANNELS-1:0]     out_index;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/max_pool_stream.sv
// Streaming per-channel signed max-pool over WINDOW beats with valid/ready back-pressure.
// Optional argmax tracking is enabled by defining MAXPOOL_ARGMAX_EN.
module max_pool_stream #(
    parameter int BITWIDTH = 16,
    parameter int CHANNELS = 4,
    parameter int WINDOW   = 4
) (
    input logic              clk,
    input logic              rst_n,
    max_pool_stream_if.slave bus
);
    localparam int IDXW = $clog2(WINDOW);
    localparam logic [IDXW-1:0] LAST_BEAT = IDXW'(WINDOW - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [IDXW-1:0]             r_cnt;
    logic signed [BITWIDTH-1:0]  r_acc [CHANNELS];
    logic [BITWIDTH*CHANNELS-1:0] r_outData;

    logic signed [BITWIDTH-1:0]  w_sample [CHANNELS];
    logic signed [BITWIDTH-1:0]  w_newAcc [CHANNELS];
    logic [CHANNELS-1:0]         w_take;
    logic                        w_inReady;
    logic                        w_accept;
    logic                        w_firstBeat;
    logic                        w_lastBeat;

    // Input stalls only while a finished result sits un-consumed.
    always_comb begin
        w_inReady   = (r_state != HOLD) || bus.out_ready;
        w_accept    = bus.in_valid && w_inReady;
        w_firstBeat = (r_cnt == '0);
        w_lastBeat  = w_accept && (r_cnt == LAST_BEAT);
        w_nextState = r_state;
        if (w_lastBeat) begin
            w_nextState = HOLD;
        end else if ((r_state == HOLD) && bus.out_ready) begin
            w_nextState = ACCUM;
        end
    end

    // First beat of a window loads unconditionally; later beats win only on strict greater-than.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_sample[c] = bus.in_data[c*BITWIDTH +: BITWIDTH];
            w_take[c]   = w_firstBeat || (w_sample[c] > r_acc[c]);
            w_newAcc[c] = w_take[c] ? w_sample[c] : r_acc[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_outData <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
        end else if (w_accept) begin
            r_cnt <= w_lastBeat ? '0 : r_cnt + 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= w_newAcc[c];
                if (w_lastBeat) begin
                    r_outData[c*BITWIDTH +: BITWIDTH] <= w_newAcc[c];
                end
            end
        end
    end

`ifdef MAXPOOL_ARGMAX_EN
    logic [IDXW-1:0]          r_idx [CHANNELS];
    logic [IDXW*CHANNELS-1:0] r_outIndex;
    logic [IDXW-1:0]          w_newIdx [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_newIdx[c] = w_take[c] ? r_cnt : r_idx[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outIndex <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_idx[c] <= '0;
            end
        end else if (w_accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_idx[c] <= w_newIdx[c];
                if (w_lastBeat) begin
                    r_outIndex[c*IDXW +: IDXW] <= w_newIdx[c];
                end
            end
        end
    end

    assign bus.out_index = r_outIndex;
`endif

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_data  = r_outData;

endmodule

// File: tb/tb_max_pool_stream.sv
// Scoreboard bench for max_pool_stream: a window-level reference model queues expected results,
// and an independent monitor checks every consumed output and the held-output rules.
module tb_max_pool_stream;
    localparam int BITWIDTH = 16;
    localparam int CHANNELS = 4;
    localparam int WINDOW   = 4;
    localparam int IDXW     = $clog2(WINDOW);
    localparam int DW       = BITWIDTH * CHANNELS;
    localparam int IW       = IDXW * CHANNELS;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    max_pool_stream_if #(.BITWIDTH(BITWIDTH), .CHANNELS(CHANNELS), .WINDOW(WINDOW)) bus ();

    max_pool_stream #(.BITWIDTH(BITWIDTH), .CHANNELS(CHANNELS), .WINDOW(WINDOW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t          expQ[$];
    logic [DW-1:0] winBeats[$];
    int            popCycles[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            readyMode   = 0;
    int            cycle       = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    task automatic flagFailure(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got timeout, expected completion", name);
    endtask

    // Reference model: buffer a whole window, then take the earliest strict maximum per channel.
    function automatic void modelAccept(input logic [DW-1:0] beat);
        exp_t                       e;
        logic [DW-1:0]              b;
        logic signed [BITWIDTH-1:0] best;
        logic signed [BITWIDTH-1:0] s;
        int                         bestK;
        winBeats.push_back(beat);
        if (winBeats.size() == WINDOW) begin
            e.data = '0;
            e.idx  = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                b     = winBeats[0];
                best  = b[c*BITWIDTH +: BITWIDTH];
                bestK = 0;
                for (int k = 1; k < WINDOW; k++) begin
                    b = winBeats[k];
                    s = b[c*BITWIDTH +: BITWIDTH];
                    if (s > best) begin
                        best  = s;
                        bestK = k;
                    end
                end
                e.data[c*BITWIDTH +: BITWIDTH] = best;
                e.idx[c*IDXW +: IDXW]          = IDXW'(bestK);
            end
            expQ.push_back(e);
            winBeats.delete();
        end
    endfunction

    function automatic logic [BITWIDTH-1:0] randSample();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'($signed($urandom_range(0, 6)) - 3);
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [DW-1:0] randBeat();
        logic [DW-1:0] b;
        for (int c = 0; c < CHANNELS; c++) begin
            b[c*BITWIDTH +: BITWIDTH] = randSample();
        end
        return b;
    endfunction

    task automatic tick();
        @(negedge clk);
        case (readyMode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    endtask

    // Called at a falling edge; holds the beat until accepted or the cycle budget runs out.
    task automatic applyStimulus(input logic [DW-1:0] beat, output bit stalled);
        bit done;
        bit last;
        done    = 1'b0;
        stalled = 1'b0;
        bus.in_data  = beat;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            if (bus.in_ready) begin
                last = (winBeats.size() == WINDOW - 1);
                modelAccept(beat);
                @(posedge clk);
                #1;
                if (last) checkOutput("latency_out_valid", DW'(bus.out_valid), DW'(1));
                tick();
                done = 1'b1;
            end else begin
                stalled = 1'b1;
                @(posedge clk);
                tick();
            end
        end
        bus.in_valid = 1'b0;
        if (!done) flagFailure("beat_accept");
    endtask

    task automatic waitDrain();
        bit drained;
        drained   = 1'b0;
        readyMode = 0;
        for (int k = 0; k < 50 && !drained; k++) begin
            tick();
            #3;
            if (expQ.size() == 0 && !bus.out_valid) drained = 1'b1;
        end
        if (!drained) flagFailure("drain");
    endtask

    // Monitor: pops the scoreboard on every consumed result and checks held results stay put.
    initial begin
        logic [DW-1:0] prevData;
        bit            prevHeld;
        exp_t          e;
        prevHeld = 1'b0;
        prevData = '0;
        forever begin
            @(negedge clk);
            #2;
            cycle++;
            if (rst_n !== 1'b1) begin
                prevHeld = 1'b0;
                continue;
            end
            checkOutput("in_ready_rule", DW'(bus.in_ready), DW'(!bus.out_valid || bus.out_ready));
            if (prevHeld) begin
                checkOutput("hold_valid", DW'(bus.out_valid), DW'(1));
                checkOutput("hold_stable", bus.out_data, prevData);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    flagFailure("spurious_output");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", bus.out_data, e.data);
`ifdef MAXPOOL_ARGMAX_EN
                    checkOutput("out_index", DW'(bus.out_index), DW'(e.idx));
`endif
                    popCycles.push_back(cycle);
                end
            end
            prevHeld = bus.out_valid && !bus.out_ready;
            prevData = bus.out_data;
        end
    end

    initial begin
        int            ch0v[WINDOW] = '{3, -7, 12, 5};
        int            ch1v[WINDOW] = '{9, 9, 2, 9};
        logic [DW-1:0] beat;
        logic [DW-1:0] heldBeat;
        bit            st;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("reset_out_data", bus.out_data, '0);
        checkOutput("reset_in_ready", DW'(bus.in_ready), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] directed windows: argmax, ties, negative extreme");
        for (int k = 0; k < WINDOW; k++) begin
            beat        = randBeat();
            beat[15:0]  = 16'(ch0v[k]);
            beat[31:16] = 16'(ch1v[k]);
            applyStimulus(beat, st);
        end
        for (int k = 0; k < WINDOW; k++) begin
            applyStimulus({CHANNELS{16'h8000}}, st);
        end
        waitDrain();

        $display("[TB] reset in the middle of a window");
        for (int k = 0; k < 2; k++) applyStimulus(randBeat(), st);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("midreset_out_data", bus.out_data, '0);
        checkOutput("midreset_in_ready", DW'(bus.in_ready), DW'(1));
        winBeats.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < WINDOW; k++) applyStimulus(randBeat(), st);
        waitDrain();

        $display("[TB] back-pressure with a pending beat");
        readyMode = 2;
        tick();
        for (int k = 0; k < WINDOW; k++) applyStimulus(randBeat(), st);
        heldBeat     = randBeat();
        bus.in_data  = heldBeat;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("bp_in_ready", DW'(bus.in_ready), DW'(0));
            @(posedge clk);
            tick();
        end
        readyMode     = 0;
        bus.out_ready = 1'b1;
        applyStimulus(heldBeat, st);
        for (int k = 1; k < WINDOW; k++) applyStimulus(randBeat(), st);
        waitDrain();

        $display("[TB] sustained streaming");
        popCycles.delete();
        for (int k = 0; k < 4 * WINDOW; k++) begin
            applyStimulus(randBeat(), st);
            checkOutput("stream_no_stall", DW'(st), DW'(0));
        end
        waitDrain();
        checkOutput("stream_results", DW'(popCycles.size()), DW'(4));
        for (int i = 1; i < popCycles.size(); i++) begin
            checkOutput("stream_spacing", DW'(popCycles[i] - popCycles[i-1]), DW'(WINDOW));
        end

        $display("[TB] random gaps and random downstream ready");
        readyMode = 1;
        for (int k = 0; k < 10 * WINDOW; k++) begin
            if ($urandom_range(0, 3) == 0) tick();
            applyStimulus(randBeat(), st);
        end
        waitDrain();
        checkOutput("scoreboard_empty", DW'(expQ.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
